// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART peripheral and its bus masters.
// Holds the register map, status bit indices, master FSM state encoding and
// the bus-drive payload with a helper that maps a state to its bus cycle.
package uart_mmio_pkg;

    localparam logic [31:0] ADDR_TX_DATA = 32'h4000_0018;
    localparam logic [31:0] ADDR_RX_DATA = 32'h4000_001C;
    localparam logic [31:0] ADDR_STATUS  = 32'h4000_0020;

    localparam int unsigned ST_TXDONE = 1;
    localparam int unsigned ST_RXRDY  = 2;
    localparam int unsigned ST_TXACT  = 3;

    typedef enum logic [1:0] {
        IDLE,
        STATUS,
        RXREAD,
        TXWRITE
    } uartMmioState_t;

    typedef struct packed {
        logic        memRead;
        logic        memWrite;
        logic        txReady;
        logic [31:0] address;
        logic [31:0] dataOut;
    } busDrive_t;

    // Bus cycle driven while the master sits in state s.
    function automatic busDrive_t busFor(uartMmioState_t s, logic [7:0] txByte);
        busDrive_t d;
        d = '0;
        case (s)
            STATUS: begin
                d.memRead = 1'b1;
                d.address = ADDR_STATUS;
            end
            RXREAD: begin
                d.memRead = 1'b1;
                d.address = ADDR_RX_DATA;
            end
            TXWRITE: begin
                d.memWrite = 1'b1;
                d.txReady  = 1'b1;
                d.address  = ADDR_TX_DATA;
                d.dataOut  = {24'h0, txByte};
            end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/uart_mmio_master.sv
// Bus initiator for the memory-mapped UART: turns a byte valid/ready stream
// into TX-register writes and polled RX-register reads into an rx_valid pulse.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   memRead, memWrite         peripheral strobes (never both high)
//   address, dataOut          peripheral address / write data
//   uartData                  combinational read data from the peripheral
//   tx_data, tx_valid         byte to send and its valid
//   tx_ready                  byte accepted this cycle
//   rx_data, rx_valid         received byte and its one-cycle valid
//   tx_busy                   a written byte has not yet reported done
//   tx_timeout                one-cycle pulse when the done wait is abandoned
module uart_mmio_master
    import uart_mmio_pkg::*;
#(
    parameter int unsigned POLL_GAP   = 16,
    parameter int unsigned TX_TIMEOUT = 200000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        memRead,
    output logic        memWrite,
    output logic [31:0] address,
    output logic [31:0] dataOut,
    input  logic [31:0] uartData,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        tx_busy,
    output logic        tx_timeout
);

    localparam int unsigned GAP_W = $clog2(POLL_GAP) + 1;
    localparam int unsigned TO_W  = $clog2(TX_TIMEOUT) + 1;
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(POLL_GAP);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TX_TIMEOUT - 1);

    uartMmioState_t   state;
    busDrive_t        bus;
    logic [GAP_W-1:0] gapCnt;
    logic [TO_W-1:0]  toCnt;

    logic doneSeen;
    logic rxSeen;
    logic sendOk;
    logic unusedHighBits;

    // Status flags are only meaningful while the status register is on the bus.
    assign doneSeen = (state == STATUS) && uartData[ST_TXDONE];
    assign rxSeen   = (state == STATUS) && uartData[ST_RXRDY];

    // A byte may go out if nothing is outstanding once this sample's done is applied.
    assign sendOk = tx_valid && !(tx_busy && !doneSeen);

    // Upper read-data bits carry nothing this master uses.
    assign unusedHighBits = ^uartData[31:8];

    assign memRead  = bus.memRead;
    assign memWrite = bus.memWrite;
    assign tx_ready = bus.txReady;
    assign address  = bus.address;
    assign dataOut  = bus.dataOut;

    // Poll FSM, counters and TX ownership; bus outputs are loaded with the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bus        <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            tx_busy    <= 1'b0;
            tx_timeout <= 1'b0;
            gapCnt     <= '0;
            toCnt      <= '0;
        end else begin
            rx_valid   <= 1'b0;
            tx_timeout <= 1'b0;

            if (state == STATUS) begin
                gapCnt <= '0;
            end else if (gapCnt != GAP_MAX) begin
                gapCnt <= gapCnt + GAP_W'(1);
            end

            // Done beats timeout when both land on the same edge.
            if (state == TXWRITE) begin
                tx_busy <= 1'b1;
                toCnt   <= '0;
            end else if (tx_busy) begin
                if (doneSeen) begin
                    tx_busy <= 1'b0;
                    toCnt   <= '0;
                end else if (toCnt == TO_LAST) begin
                    tx_busy    <= 1'b0;
                    tx_timeout <= 1'b1;
                    toCnt      <= '0;
                end else begin
                    toCnt <= toCnt + TO_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (tx_busy || (gapCnt == GAP_MAX) || sendOk) begin
                        state <= STATUS;
                        bus   <= busFor(STATUS, tx_data);
                    end else begin
                        state <= IDLE;
                        bus   <= busFor(IDLE, tx_data);
                    end
                end
                STATUS: begin
                    // RX wins; a waiting byte follows the RX read.
                    if (rxSeen) begin
                        state <= RXREAD;
                        bus   <= busFor(RXREAD, tx_data);
                    end else if (sendOk) begin
                        state <= TXWRITE;
                        bus   <= busFor(TXWRITE, tx_data);
                    end else begin
                        state <= IDLE;
                        bus   <= busFor(IDLE, tx_data);
                    end
                end
                RXREAD: begin
                    rx_data  <= uartData[7:0];
                    rx_valid <= 1'b1;
                    if (sendOk) begin
                        state <= TXWRITE;
                        bus   <= busFor(TXWRITE, tx_data);
                    end else begin
                        state <= IDLE;
                        bus   <= busFor(IDLE, tx_data);
                    end
                end
                TXWRITE: begin
                    state <= IDLE;
                    bus   <= busFor(IDLE, tx_data);
                end
                default: begin
                    state <= IDLE;
                    bus   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_mmio_master.md
# uart_mmio_master

Bus initiator for the memory-mapped UART peripheral. It is the CPU-side counterpart that drives `memRead`, `memWrite`, `address` and data on the peripheral bus, and reads back `uartData`. It turns a byte-stream valid/ready handshake into TX-register writes, and polled RX-register reads into a byte-valid pulse. It sits in the debug/loader path in place of software polling; an external mux selects between it and the CPU.

## Interface
- `POLL_GAP`, 16: idle cycles between status polls when no TX is outstanding (0 = poll every idle cycle).
- `TX_TIMEOUT`, 200000: cycles to wait for TX-done before abandoning the byte.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous and active-high.
- `memRead`  out  1  peripheral read strobe.
- `memWrite`  out  1  peripheral write strobe.
- `address`  out  32  peripheral address.
- `dataOut`  out  32  write data to peripheral.
- `uartData`  in  32  combinational read data from peripheral, valid in the same cycle as `address`/`memRead`.
- `tx_data`  in  8  byte to send.
- `tx_valid`  in  1  `tx_data` valid.
- `tx_ready`  out  1  byte accepted this cycle.
- `rx_data`  out  8  received byte.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` valid.
- `tx_busy`  out  1  a written byte has not yet reported done.
- `tx_timeout`  out  1  one-cycle pulse when `TX_TIMEOUT` expires.

## Operation
- Register map: TX data `0x40000018` (write, low byte); RX data `0x4000001C` (read, `{24'h0, byte}`); status `0x40000020` (read).
- Status bits: bit1 = TX done, bit2 = RX ready, bit3 = TX active. Reading the status register clears bit1 and bit2 in the peripheral at that clock edge.
- FSM states: IDLE, STATUS, RXREAD, TXWRITE.
- IDLE: strobes low, `address`=0, `dataOut`=0. Go to STATUS when either:
  - `tx_busy`, or
  - the gap counter has reached `POLL_GAP`, or
  - `tx_valid && !tx_busy`.
- STATUS, one cycle: `memRead`=1, `address`=status. Sample `uartData` at the edge:
  - bit1 set: clear `tx_busy`.
  - bit2 set: next state is RXREAD.
  - otherwise, if `tx_valid && !tx_busy` (after this sample's clear): next state is TXWRITE.
  - otherwise: next state is IDLE.
  - Both flags are consumed from one sample. A flag seen and not acted on is lost; the FSM must act on both.
- RXREAD, one cycle: `memRead`=1, `address`=RX data. Register `uartData[7:0]` into `rx_data` and pulse `rx_valid` in the following cycle. Then go to TXWRITE if `tx_valid && !tx_busy`, else IDLE. RX has priority over TX.
- TXWRITE, one cycle: `memWrite`=1, `address`=TX data, `dataOut`=`{24'h0, tx_data}`, `tx_ready`=1. Set `tx_busy` and clear the timeout counter. Go to IDLE.
- Timeout counter increments every cycle while `tx_busy`. At `TX_TIMEOUT`-1: clear `tx_busy`, pulse `tx_timeout`.
- Gap counter resets on every STATUS and saturates at `POLL_GAP`.
- At most one byte is outstanding; `tx_ready` is never asserted while `tx_busy`.

## Timing
- Reset: all outputs 0, FSM in IDLE, both counters 0.
- `memRead` and `memWrite` are never high in the same cycle. Each access is exactly one cycle with no wait states.
- From `tx_valid` rising in IDLE with `!tx_busy`, `tx_ready` is high 2 cycles later (STATUS, then TXWRITE), or 3 cycles later if RX is pending.
- `rx_valid` is high 1 cycle after RXREAD, i.e. 2 cycles after the STATUS sample that saw bit2.
- Simultaneous TX-done and RX-ready in one sample: clear `tx_busy`, then RXREAD, then TXWRITE if a byte is waiting.
- Timeout and done in the same cycle: done wins, and `tx_timeout` is not pulsed.
- `rst` mid-access: strobes drop in the same cycle `rst` is sampled. An in-flight TX is forgotten.
- `tx_valid` may drop before `tx_ready` without error.

## Structure
- Shared package `uart_mmio_pkg`: the three register addresses, the status bit indices (`ST_TXDONE`=1, `ST_RXRDY`=2, `ST_TXACT`=3), and the FSM state enum. The peripheral uses the same package.
- Single flat module; no sub-module. Counters are inline, with widths `$clog2` of the respective parameter plus 1.

## Test plan
- Reset: assert `rst` for 3 cycles with `tx_valid`=1 → all outputs 0, no strobe until 1 cycle after release.
- Single TX: `tx_data`=`0x41` → STATUS read at `0x40000020`, then write of `0x00000041` to `0x40000018`, `tx_ready` pulse, `tx_busy`=1. Model returns bit1 in 50 cycles → `tx_busy` clears on that status read.
- Back-to-back TX: bytes `0x55`, `0xAA` → second `tx_ready` only after the status sample showing bit1. Never two writes without an intervening done.
- RX: model sets bit2 with data `0x5A` → read of `0x4000001C`, `rx_data`=`0x5A`, `rx_valid` for exactly 1 cycle.
- Simultaneous events: status=`0x6` with a TX byte `0x33` waiting → sequence STATUS, RXREAD, TXWRITE; `tx_busy` cleared, then set again.
- Timeout: `TX_TIMEOUT`=100, model never reports done → `tx_timeout` pulses 100 cycles after TXWRITE, `tx_busy`=0, next byte accepted.
